fsmc_slot_arbiter: RTL and testbench

Sequences host accesses from the FSMC bus interface onto a set of register slots. It sits between the FSMC interface (its `cs`, `state`, `wr_data`, `rd_data` side) and the register/peripheral blocks, replacing direct `cs[i]` fan-out. It turns each level-style host access into a single registered request/acknowledge transaction with exactly one slot. It returns read data, bounds slot response time and flags protocol errors.

---
 rtl/fsmc_slot_arbiter.sv | 159 +++++++++++++++
 tb/tb_fsmc_slot_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsmc_slot_arbiter.sv
// FSMC host-access sequencer: turns level chip-selects into one registered req/ack transaction per slot.
// Optional slot response timeout is enabled with `define FSMC_ARB_TIMEOUT_EN.
module fsmc_slot_arbiter #(
  parameter int unsigned NSLOT   = 4,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NSLOT-1:0]    cs,
  input  logic                state,
  input  logic [DW-1:0]       wr_data,
  output logic [DW-1:0]       rd_data,
  output logic [NSLOT-1:0]    slot_req,
  output logic                slot_we,
  output logic [DW-1:0]       slot_wdata,
  input  logic [NSLOT*DW-1:0] slot_rdata,
  input  logic [NSLOT-1:0]    slot_ack,
  output logic                busy,
  output logic                err_overlap,
  output logic                err_timeout,
  input  logic                err_clr
);

  localparam int unsigned IW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("fsmc_slot_arbiter: TIMEOUT must be at least 2");
  end

`ifdef FSMC_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  logic [1:0]       fsm_q, fsm_d;
  logic             armed_q;
  logic [NSLOT-1:0] cs_q;
  logic [IW-1:0]    idx_q, idx_d, low_idx;
  logic [DW-1:0]    rd_data_d, wdata_d, sel_rdata;
  logic [NSLOT-1:0] req_d;
  logic             we_d, ovl_d, to_d, sel_ack, start, multi;

  assign start = armed_q && (cs != '0) && (cs_q == '0);
  assign multi = (cs & (cs - NSLOT'(1))) != '0;

  // Lowest set chip-select wins when several are asserted
  always_comb begin
    low_idx = '0;
    for (int i = int'(NSLOT) - 1; i >= 0; i--) begin
      if (cs[i]) low_idx = IW'(i);
    end
  end

  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < int'(NSLOT); i++) begin
      if (idx_q == IW'(i)) begin
        sel_ack   = slot_ack[i];
        sel_rdata = slot_rdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    idx_d     = idx_q;
    rd_data_d = rd_data;
    req_d     = slot_req;
    we_d      = slot_we;
    wdata_d   = slot_wdata;
    ovl_d     = err_overlap;
    to_d      = err_timeout;
`ifdef FSMC_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    if (err_clr) begin
      ovl_d = 1'b0;
      to_d  = 1'b0;
    end
    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = low_idx;
          we_d    = ~state;
          wdata_d = wr_data;
          req_d   = NSLOT'(1) << low_idx;
          fsm_d   = S_REQ;
          if (multi) ovl_d = 1'b1;
`ifdef FSMC_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_REQ: begin
        if (sel_ack) begin
          if (!slot_we) rd_data_d = sel_rdata;
          req_d = '0;
          fsm_d = S_RELEASE;
        end
`ifdef FSMC_ARB_TIMEOUT_EN
        // Last allowed cycle without ack: abandon the slot and poison read data
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          if (!slot_we) rd_data_d = DW'(16'hDEAD);
          to_d  = 1'b1;
          req_d = '0;
          fsm_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_RELEASE: begin
        if (cs == '0) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm_q       <= S_IDLE;
      armed_q     <= 1'b0;
      cs_q        <= '0;
      idx_q       <= '0;
      rd_data     <= '0;
      slot_req    <= '0;
      slot_we     <= 1'b0;
      slot_wdata  <= '0;
      busy        <= 1'b0;
      err_overlap <= 1'b0;
      err_timeout <= 1'b0;
`ifdef FSMC_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      fsm_q       <= fsm_d;
      armed_q     <= armed_q | (cs == '0);
      cs_q        <= cs;
      idx_q       <= idx_d;
      rd_data     <= rd_data_d;
      slot_req    <= req_d;
      slot_we     <= we_d;
      slot_wdata  <= wdata_d;
      busy        <= (fsm_d != S_IDLE);
      err_overlap <= ovl_d;
      err_timeout <= to_d;
`ifdef FSMC_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_fsmc_slot_arbiter.sv
// Directed bench for fsmc_slot_arbiter with a transaction-level reference model checked every cycle.
module tb_fsmc_slot_arbiter;

  localparam int unsigned TIMEOUT = 15;
`ifdef FSMC_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  cs;
  logic        state;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic [3:0]  slot_req;
  logic        slot_we;
  logic [15:0] slot_wdata;
  logic [63:0] slot_rdata;
  logic [3:0]  slot_ack;
  logic        busy, err_overlap, err_timeout, err_clr;
  logic [3:0]  comb_mask, ack_man;

  always #5 clk = ~clk;

  // Slots either ack combinationally on their request or by explicit pulse
  assign slot_ack = (slot_req & comb_mask) | ack_man;

  fsmc_slot_arbiter #(.NSLOT(4), .DW(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .state(state), .wr_data(wr_data),
    .rd_data(rd_data), .slot_req(slot_req), .slot_we(slot_we), .slot_wdata(slot_wdata),
    .slot_rdata(slot_rdata), .slot_ack(slot_ack), .busy(busy),
    .err_overlap(err_overlap), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Input values as seen just before the next rising edge
  logic [3:0]  s_cs, s_ack;
  logic        s_state, s_rst_n, s_clr;
  logic [15:0] s_wdata;
  logic [63:0] s_rdata;
  always @(negedge clk) begin
    s_cs = cs; s_ack = slot_ack; s_state = state; s_rst_n = reset_n;
    s_clr = err_clr; s_wdata = wr_data; s_rdata = slot_rdata;
  end

  // Reference model: one access = request phase (m_req != 0) then release phase
  bit          m_armed, m_busy, m_read, m_ovl, m_to;
  int          m_age;
  logic [3:0]  m_cs_prev, m_req;
  logic        m_we;
  logic [15:0] m_wdata, m_rd;

  always @(posedge clk) begin
    bit n_ovl, n_to;
    if (!s_rst_n) begin
      m_armed = 0; m_busy = 0; m_read = 0; m_ovl = 0; m_to = 0; m_age = 0;
      m_cs_prev = '0; m_req = '0; m_we = 0; m_wdata = '0; m_rd = '0;
    end else begin
      n_ovl = m_ovl && !s_clr;
      n_to  = m_to && !s_clr;
      if (!m_busy) begin
        if (m_armed && s_cs != 0 && m_cs_prev == 0) begin
          m_req   = s_cs & (~s_cs + 4'd1);
          m_we    = !s_state;
          m_read  = s_state;
          m_wdata = s_wdata;
          m_busy  = 1;
          m_age   = 0;
          if (s_cs != m_req) n_ovl = 1;
        end
      end else if (m_req != 0) begin
        m_age++;
        if ((s_ack & m_req) != 0) begin
          if (m_read)
            for (int i = 0; i < 4; i++) if (m_req[i]) m_rd = s_rdata[i*16 +: 16];
          m_req = '0;
        end else if (TO_EN && m_age == int'(TIMEOUT)) begin
          if (m_read) m_rd = 16'hDEAD;
          n_to  = 1;
          m_req = '0;
        end
      end else if (s_cs == 0) begin
        m_busy = 0;
      end
      if (s_cs == 0) m_armed = 1;
      m_cs_prev = s_cs;
      m_ovl = n_ovl;
      m_to  = n_to;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_rd_data", 32'(rd_data), 32'(m_rd));
      chk("model_slot_req", 32'(slot_req), 32'(m_req));
      chk("model_busy", 32'(busy), 32'(m_busy));
      chk("model_err_overlap", 32'(err_overlap), 32'(m_ovl));
      chk("model_err_timeout", 32'(err_timeout), 32'(m_to));
      if (m_req != 0) begin
        chk("model_slot_we", 32'(slot_we), 32'(m_we));
        chk("model_slot_wdata", 32'(slot_wdata), 32'(m_wdata));
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_n = 0; cs = 4'b0001; state = 0; wr_data = '0; slot_rdata = '0;
    err_clr = 0; comb_mask = '0; ack_man = '0;
    tick(2);
    cmp_en = 1;
    chk("reset_outputs", {rd_data, slot_req, slot_we, busy, err_overlap, err_timeout, 8'h0},
        32'h0);
    chk("reset_wdata", 32'(slot_wdata), 32'h0);

    // Access held across reset release is ignored
    reset_n = 1;
    tick(10);
    chk("held_cs_no_req", 32'(slot_req), 32'h0);
    chk("held_cs_not_busy", 32'(busy), 32'h0);

    // Immediate-ack read of slot 0
    cs = 4'b0000; tick();
    cs = 4'b0001; state = 1; slot_rdata[15:0] = 16'h1234; comb_mask = 4'b0001;
    tick();
    chk("rd0_req", 32'(slot_req), 32'h1);
    chk("rd0_we", 32'(slot_we), 32'h0);
    tick();
    chk("rd0_req_drop", 32'(slot_req), 32'h0);
    chk("rd0_data", 32'(rd_data), 32'h1234);
    comb_mask = '0;

    // Write to slot 2 with ack sampled on the third request cycle
    cs = 4'b0000; tick();
    cs = 4'b0100; state = 0; wr_data = 16'hA5A5;
    tick();
    wr_data = 16'h0000;
    chk("wr2_req", 32'(slot_req), 32'h4);
    chk("wr2_we", 32'(slot_we), 32'h1);
    chk("wr2_wdata", 32'(slot_wdata), 32'hA5A5);
    tick(2);
    chk("wr2_req_held", 32'(slot_req), 32'h4);
    ack_man = 4'b0100;
    tick();
    ack_man = '0;
    chk("wr2_req_drop", 32'(slot_req), 32'h0);
    chk("wr2_rd_unchanged", 32'(rd_data), 32'h1234);

    // Overlapping chip-selects pick the lowest slot and flag an error
    cs = 4'b0000; tick();
    cs = 4'b1010; state = 1; slot_rdata[31:16] = 16'h5A5A; comb_mask = 4'b0010;
    tick();
    chk("ovl_req", 32'(slot_req), 32'h2);
    chk("ovl_flag", 32'(err_overlap), 32'h1);
    tick();
    chk("ovl_rd", 32'(rd_data), 32'h5A5A);
    comb_mask = '0;
    cs = 4'b0000; err_clr = 1; tick();
    err_clr = 0;
    chk("ovl_cleared", 32'(err_overlap), 32'h0);

    // Ack from a non-selected slot is ignored
    cs = 4'b1000; state = 1; slot_rdata[63:48] = 16'h00FF;
    tick();
    chk("wack_req", 32'(slot_req), 32'h8);
    ack_man = 4'b0001; tick();
    ack_man = '0; tick();
    chk("wack_req_held", 32'(slot_req), 32'h8);
    ack_man = 4'b1000; tick();
    ack_man = '0;
    chk("wack_req_drop", 32'(slot_req), 32'h0);
    chk("wack_rd", 32'(rd_data), 32'h00FF);

    // Silent slot: timeout when enabled, otherwise request waits indefinitely
    cs = 4'b0000; tick();
    cs = 4'b0001; state = 1;
    tick();
    tick(14);
    chk("to_req_held14", 32'(slot_req), 32'h1);
    tick();
    if (TO_EN) begin
      chk("to_req_drop", 32'(slot_req), 32'h0);
      chk("to_rd_dead", 32'(rd_data), 32'hDEAD);
      chk("to_flag", 32'(err_timeout), 32'h1);
    end else begin
      chk("nto_req_held15", 32'(slot_req), 32'h1);
      tick(5);
      ack_man = 4'b0001; tick();
      ack_man = '0;
      chk("nto_rd", 32'(rd_data), 32'h1234);
    end

    // Ack on the last allowed cycle completes normally
    cs = 4'b0000; err_clr = 1; tick();
    err_clr = 0;
    cs = 4'b0001; state = 1; slot_rdata[15:0] = 16'hBEEF;
    tick();
    tick(14);
    ack_man = 4'b0001; tick();
    ack_man = '0;
    chk("ack15_req_drop", 32'(slot_req), 32'h0);
    chk("ack15_rd", 32'(rd_data), 32'hBEEF);
    chk("ack15_no_err", 32'(err_timeout), 32'h0);

    // Host abort: cs drops right after the start, slot acks later
    cs = 4'b0000; tick();
    cs = 4'b0100; state = 1; slot_rdata[47:32] = 16'h7777;
    tick();
    cs = 4'b0000;
    tick(3);
    ack_man = 4'b0100; tick();
    ack_man = '0;
    chk("abort_req_drop", 32'(slot_req), 32'h0);
    chk("abort_busy_release", 32'(busy), 32'h1);
    chk("abort_rd", 32'(rd_data), 32'h7777);
    tick();
    chk("abort_idle", 32'(busy), 32'h0);

    // Nonzero-to-nonzero cs change is not a new start
    cs = 4'b0001; state = 0; comb_mask = 4'b1111;
    tick(2);
    cs = 4'b0010; tick(3);
    chk("nz_no_restart", 32'(slot_req), 32'h0);
    chk("nz_still_busy", 32'(busy), 32'h1);
    comb_mask = '0;
    cs = 4'b0000; tick(2);
    chk("nz_idle", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
